// File: rtl/cpu_control_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module : cpu_control_unit_pkg
// Brief  : Opcodes, ALU codes, decode classes and FSM states for the sequencer.
// Rev    : 1.0
// ============================================================================
package cpu_control_unit_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_LD  = 4'h7;
    localparam logic [3:0] OP_ST  = 4'h8;
    localparam logic [3:0] OP_JMP = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [3:0] ALU_HOLD   = 4'd0;
    localparam logic [3:0] ALU_PASS_B = 4'd1;
    localparam logic [3:0] ALU_ADD    = 4'd2;
    localparam logic [3:0] ALU_SUB    = 4'd3;
    localparam logic [3:0] ALU_AND    = 4'd4;
    localparam logic [3:0] ALU_OR     = 4'd5;
    localparam logic [3:0] ALU_XOR    = 4'd6;

    typedef enum logic [2:0] {
        CL_NOP, CL_ALU, CL_LD, CL_ST, CL_JMP, CL_JZ, CL_HLT
    } op_class_e;

    typedef enum logic [2:0] {
        ST_FETCH_OP, ST_FETCH_ARG, ST_LD_WAIT, ST_FLUSH, ST_HALT
    } state_e;

endpackage
`default_nettype wire

// File: rtl/cpu_control_unit_instr_decoder.sv
`default_nettype none
// ============================================================================
// Module : cpu_control_unit_instr_decoder
// Brief  : Combinational opcode decode into class, ALU code and illegal flag.
// Rev    : 1.0
// ============================================================================
module cpu_control_unit_instr_decoder
    import cpu_control_unit_pkg::*;
(
    input  logic [3:0] op,
    output op_class_e  op_class,
    output logic [3:0] alu_code,
    output logic       illegal
);

    always_comb begin
        op_class = CL_NOP;
        alu_code = ALU_HOLD;
        illegal  = 1'b0;
        case (op)
            OP_NOP: op_class = CL_NOP;
            OP_LDI: begin op_class = CL_ALU; alu_code = ALU_PASS_B; end
            OP_ADD: begin op_class = CL_ALU; alu_code = ALU_ADD;    end
            OP_SUB: begin op_class = CL_ALU; alu_code = ALU_SUB;    end
            OP_AND: begin op_class = CL_ALU; alu_code = ALU_AND;    end
            OP_OR:  begin op_class = CL_ALU; alu_code = ALU_OR;     end
            OP_XOR: begin op_class = CL_ALU; alu_code = ALU_XOR;    end
            OP_LD:  op_class = CL_LD;
            OP_ST:  op_class = CL_ST;
            OP_JMP: op_class = CL_JMP;
            OP_JZ:  op_class = CL_JZ;
            OP_HLT: op_class = CL_HLT;
            // Undefined opcodes behave as NOP but are flagged.
            default: illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cpu_control_unit.sv
`default_nettype none
// ============================================================================
// Module : cpu_control_unit
// Brief  : Two-byte instruction sequencer driving the accumulator datapath.
// Rev    : 1.0
// ============================================================================
module cpu_control_unit
    import cpu_control_unit_pkg::*;
#(
    parameter int LOAD_LAT  = 2,
    parameter int FLUSH_CYC = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             im_valid,
    input  logic [7:0]       im_data,
    input  logic             ac_zero,
    output logic             jump_to_addr,
    output logic [3:0]       alu_control,
    output logic             rd_dmem,
    output logic             wr_dmem,
    output logic             halted,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam int WAIT_MAX = (LOAD_LAT > FLUSH_CYC) ? LOAD_LAT : FLUSH_CYC;
    localparam int WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;
    localparam logic [WAIT_W-1:0] LD_INIT    = WAIT_W'(LOAD_LAT - 1);
    localparam logic [WAIT_W-1:0] FLUSH_INIT = WAIT_W'(FLUSH_CYC - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

    state_e            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              retire;

    logic [3:0]        dec_op;
    op_class_e         dec_class;
    logic [3:0]        dec_alu;
    logic              dec_illegal;

    // Operand low nibble belongs to the datapath only.
    logic unused_operand_bits;
    assign unused_operand_bits = ^im_data[3:0];

    // Decode the live byte while fetching, the latched opcode afterwards.
    assign dec_op = (state_q == ST_FETCH_OP) ? im_data[7:4] : op_q;

    cpu_control_unit_instr_decoder u_decoder (
        .op       (dec_op),
        .op_class (dec_class),
        .alu_code (dec_alu),
        .illegal  (dec_illegal)
    );

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        wait_d       = wait_q;
        retire       = 1'b0;
        alu_control  = ALU_HOLD;
        jump_to_addr = 1'b0;
        rd_dmem      = 1'b0;
        wr_dmem      = 1'b0;
        illegal_op   = 1'b0;
        case (state_q)
            ST_FETCH_OP: begin
                if (run && im_valid) begin
                    if (dec_class == CL_HLT) begin
                        state_d = ST_HALT;
                        retire  = 1'b1;
                    end else begin
                        op_d       = im_data[7:4];
                        illegal_op = dec_illegal;
                        state_d    = ST_FETCH_ARG;
                    end
                end
            end
            ST_FETCH_ARG: begin
                if (im_valid) begin
                    state_d = ST_FETCH_OP;
                    retire  = 1'b1;
                    case (dec_class)
                        CL_ALU: alu_control = dec_alu;
                        CL_ST:  wr_dmem     = 1'b1;
                        CL_LD: begin
                            rd_dmem = 1'b1;
                            wait_d  = LD_INIT;
                            state_d = ST_LD_WAIT;
                            retire  = 1'b0;
                        end
                        CL_JMP, CL_JZ: begin
                            if (dec_class == CL_JMP || ac_zero) begin
                                jump_to_addr = 1'b1;
                                wait_d       = FLUSH_INIT;
                                state_d      = ST_FLUSH;
                                retire       = 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_LD_WAIT, ST_FLUSH: begin
                if (wait_q == '0) begin
                    state_d = ST_FETCH_OP;
                    retire  = 1'b1;
                end else begin
                    wait_d = wait_q - WAIT_ONE;
                end
            end
            ST_HALT: ;
            default: state_d = ST_FETCH_OP;
        endcase
        cnt_d = retire ? (cnt_q + CNT_ONE) : cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_FETCH_OP;
            op_q    <= OP_NOP;
            wait_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
        end
    end

    assign halted      = (state_q == ST_HALT);
    assign retired_cnt = cnt_q;

    a_one_strobe: assert property (@(posedge clk) disable iff (reset)
        $onehot0({jump_to_addr, rd_dmem, wr_dmem}));

endmodule
`default_nettype wire

// File: tb/tb_cpu_control_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_cpu_control_unit
// Brief  : Directed vector bench for the instruction sequencer.
// Rev    : 1.0
// ============================================================================
module tb_cpu_control_unit;

    typedef struct {
        logic        run;
        logic        vld;
        logic [7:0]  d;
        logic        z;
        logic        jmp;
        logic [3:0]  alu;
        logic        rd;
        logic        wr;
        logic        hlt;
        logic        ill;
        logic [15:0] cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, run, im_valid, ac_zero;
    logic [7:0]  im_data;
    logic        jump_to_addr, rd_dmem, wr_dmem, halted, illegal_op;
    logic [3:0]  alu_control;
    logic [15:0] retired_cnt;
    logic        j2, rd2, wr2, h2, il2;
    logic [3:0]  a2;
    logic [3:0]  cnt2;

    int checks = 0;
    int failures = 0;
    vec_t vecs[31];

    always #5 clk = ~clk;

    cpu_control_unit dut (
        .clk(clk), .reset(reset), .run(run), .im_valid(im_valid),
        .im_data(im_data), .ac_zero(ac_zero), .jump_to_addr(jump_to_addr),
        .alu_control(alu_control), .rd_dmem(rd_dmem), .wr_dmem(wr_dmem),
        .halted(halted), .illegal_op(illegal_op), .retired_cnt(retired_cnt)
    );

    // Narrow counter copy sharing the same stimulus, used to observe wrap.
    cpu_control_unit #(.CNT_W(4)) dut_w4 (
        .clk(clk), .reset(reset), .run(run), .im_valid(im_valid),
        .im_data(im_data), .ac_zero(ac_zero), .jump_to_addr(j2),
        .alu_control(a2), .rd_dmem(rd2), .wr_dmem(wr2),
        .halted(h2), .illegal_op(il2), .retired_cnt(cnt2)
    );

    function automatic vec_t mkv(input logic r, input logic v, input logic [7:0] d,
                                 input logic z, input logic j, input logic [3:0] a,
                                 input logic rd, input logic wr, input logic h,
                                 input logic il, input logic [15:0] c);
        vec_t t;
        t.run = r; t.vld = v; t.d = d; t.z = z; t.jmp = j; t.alu = a;
        t.rd = rd; t.wr = wr; t.hlt = h; t.ill = il; t.cnt = c;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input vec_t e);
        chk({tag, ".jump"},    {31'd0, jump_to_addr}, {31'd0, e.jmp});
        chk({tag, ".alu"},     {28'd0, alu_control},  {28'd0, e.alu});
        chk({tag, ".rd"},      {31'd0, rd_dmem},      {31'd0, e.rd});
        chk({tag, ".wr"},      {31'd0, wr_dmem},      {31'd0, e.wr});
        chk({tag, ".halted"},  {31'd0, halted},       {31'd0, e.hlt});
        chk({tag, ".illegal"}, {31'd0, illegal_op},   {31'd0, e.ill});
        chk({tag, ".cnt"},     {16'd0, retired_cnt},  {16'd0, e.cnt});
    endtask

    // Drive one cycle just after posedge, check before the next posedge.
    task automatic apply(input string tag, input vec_t e);
        run = e.run; im_valid = e.vld; im_data = e.d; ac_zero = e.z;
        @(negedge clk);
        chk_outs(tag, e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_expect(input string tag, input logic [15:0] c);
        chk_outs(tag, mkv(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, c));
    endtask

    initial begin
        //                r     v     data   z     jmp   alu   rd    wr    hlt   ill   cnt
        vecs[0]  = mkv(1'b1, 1'b1, 8'h10, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        vecs[1]  = mkv(1'b1, 1'b1, 8'h05, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        vecs[2]  = mkv(1'b1, 1'b1, 8'h20, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1);
        vecs[3]  = mkv(1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1);
        vecs[4]  = mkv(1'b1, 1'b1, 8'h70, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2);
        vecs[5]  = mkv(1'b1, 1'b1, 8'h10, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2);
        vecs[6]  = mkv(1'b1, 1'b1, 8'h99, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2);
        vecs[7]  = mkv(1'b1, 1'b1, 8'h99, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2);
        vecs[8]  = mkv(1'b1, 1'b1, 8'h20, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3);
        vecs[9]  = mkv(1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3);
        vecs[10] = mkv(1'b1, 1'b1, 8'hA0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4);
        vecs[11] = mkv(1'b1, 1'b1, 8'h20, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4);
        vecs[12] = mkv(1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4);
        vecs[13] = mkv(1'b1, 1'b1, 8'hA0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5);
        vecs[14] = mkv(1'b1, 1'b1, 8'h30, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5);
        vecs[15] = mkv(1'b1, 1'b1, 8'hC0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd6);
        vecs[16] = mkv(1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd6);
        vecs[17] = mkv(1'b1, 1'b1, 8'h80, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd7);
        vecs[18] = mkv(1'b1, 1'b1, 8'h44, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd7);
        vecs[19] = mkv(1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd8);
        vecs[20] = mkv(1'b1, 1'b0, 8'h10, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd8);
        vecs[21] = mkv(1'b1, 1'b1, 8'h10, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd8);
        vecs[22] = mkv(1'b1, 1'b0, 8'h05, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd8);
        vecs[23] = mkv(1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd8);
        vecs[24] = mkv(1'b1, 1'b1, 8'h90, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd9);
        vecs[25] = mkv(1'b1, 1'b1, 8'h40, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd9);
        vecs[26] = mkv(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd9);
        vecs[27] = mkv(1'b1, 1'b1, 8'hF0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd10);
        vecs[28] = mkv(1'b1, 1'b1, 8'h10, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd11);
        vecs[29] = mkv(1'b0, 1'b1, 8'h20, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd11);
        vecs[30] = mkv(1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd11);

        reset = 1'b1; run = 1'b0; im_valid = 1'b0; im_data = 8'h00; ac_zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        idle_expect("reset", 16'd0);
        reset = 1'b0;

        for (int i = 0; i < 31; i++)
            apply($sformatf("vec%0d", i), vecs[i]);

        // Reset out of HALT is asynchronous: counter and halted clear at once.
        reset = 1'b1;
        #1;
        idle_expect("halt_reset", 16'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Reset in the middle of LD_WAIT.
        apply("ldr0", mkv(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
        apply("ldr1", mkv(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
        apply("ldr2", mkv(1'b1, 1'b1, 8'h70, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1));
        apply("ldr3", mkv(1'b1, 1'b1, 8'h10, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1));
        im_data = 8'h99;
        @(negedge clk);
        idle_expect("ld_wait", 16'd1);
        #2 reset = 1'b1;
        #1;
        idle_expect("ld_wait_reset", 16'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        apply("ldr4", mkv(1'b1, 1'b1, 8'h10, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
        apply("ldr5", mkv(1'b1, 1'b1, 8'h05, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));

        // Reset while stalled in FETCH_ARG.
        apply("far0", mkv(1'b1, 1'b1, 8'h10, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1));
        run = 1'b1; im_valid = 1'b0; im_data = 8'h05;
        @(negedge clk);
        idle_expect("arg_stall", 16'd1);
        #2 reset = 1'b1;
        #1;
        idle_expect("arg_stall_reset", 16'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        apply("far1", mkv(1'b1, 1'b1, 8'h10, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
        apply("far2", mkv(1'b1, 1'b1, 8'h06, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));

        // Counter wrap, observed on the 4-bit copy after 16 NOPs.
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 15)
                chk("w4_cnt15", {28'd0, cnt2}, 32'd15);
            apply($sformatf("nop%0da", i),
                  mkv(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'(i)));
            apply($sformatf("nop%0db", i),
                  mkv(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'(i)));
        end
        chk("cnt16", {16'd0, retired_cnt}, 32'd16);
        chk("w4_wrap", {28'd0, cnt2}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
